gerador_strobe: RTL and testbench

Multi-channel, runtime-programmable strobe generator: the parametrised successor of the single fixed-divisor 1-cycle strobe divider. It produces N_CH independent 1-cycle enable pulses from `clk_in`, one per channel. Each channel's divisor is written at run time through a single-cycle write port. Consumers are the motor PWM update tick, the sensor sampling tick and the display/debug refresh, all in the `clk_in` (27 MHz) domain.

---
 rtl/gerador_strobe.sv | 95 +++++++++
 tb/tb_gerador_strobe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerador_strobe.sv
// gerador_strobe: N_CH independent, runtime-programmable 1-cycle strobe dividers.
// Optional one-shot channel mode is compiled in when GERADOR_STROBE_ONESHOT_EN is defined.
module gerador_strobe #(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 25,
    parameter int DIV_RESET  = 27000000,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_oneshot,
    output logic             wr_ack,
    output logic             wr_err,
    output logic [N_CH-1:0]  tick
);

    logic [WIDTH-1:0] div [N_CH];
    logic [WIDTH-1:0] cnt [N_CH];
    logic             wr_ok;

`ifdef GERADOR_STROBE_ONESHOT_EN
    logic [N_CH-1:0]  mode;
    logic [N_CH-1:0]  armed;
`else
    logic             unused_oneshot;
    assign unused_oneshot = wr_oneshot;
`endif

    assign wr_ok = (32'(wr_ch) < N_CH) && (wr_div != '0);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                div[i] <= WIDTH'(DIV_RESET);
                cnt[i] <= '0;
            end
`ifdef GERADOR_STROBE_ONESHOT_EN
            mode  <= '0;
            armed <= '1;
`endif
            tick   <= '0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_en && wr_ok;
            wr_err <= wr_en && !wr_ok;
            for (int unsigned i = 0; i < N_CH; i++) begin
                // A write to this channel outranks restart and the terminal count.
                if (wr_en && wr_ok && (wr_ch == CH_W'(i))) begin
                    div[i]  <= wr_div;
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
`ifdef GERADOR_STROBE_ONESHOT_EN
                    mode[i]  <= wr_oneshot;
                    armed[i] <= 1'b1;
`endif
                end else if (restart) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
`ifdef GERADOR_STROBE_ONESHOT_EN
                    armed[i] <= 1'b1;
`endif
                end else if (en) begin
`ifdef GERADOR_STROBE_ONESHOT_EN
                    // A fired one-shot channel parks at zero until re-armed.
                    if (mode[i] && !armed[i]) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b0;
                    end else
`endif
                    if (cnt[i] == div[i] - WIDTH'(1)) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
`ifdef GERADOR_STROBE_ONESHOT_EN
                        if (mode[i]) begin
                            armed[i] <= 1'b0;
                        end
`endif
                    end else begin
                        cnt[i]  <= cnt[i] + WIDTH'(1);
                        tick[i] <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gerador_strobe.sv
// Self-checking bench for gerador_strobe: edge-count reference model plus directed and random stimulus.
module tb_gerador_strobe;

    // Three channels so that a 2-bit wr_ch can encode an out-of-range channel (3).
    localparam int NCH   = 3;
    localparam int W     = 8;
    localparam int DRST  = 4;
    localparam int CHW   = 2;
`ifdef GERADOR_STROBE_ONESHOT_EN
    localparam bit ONESHOT_BUILD = 1'b1;
`else
    localparam bit ONESHOT_BUILD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           restart = 1'b0;
    logic           wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [W-1:0]   wr_div = '0;
    logic           wr_oneshot = 1'b0;
    logic           wr_ack;
    logic           wr_err;
    logic [NCH-1:0] tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ticks derive from the number of enabled edges since the channel's last clear.
    int             m_div   [NCH];
    int             m_edges [NCH];
    bit             m_mode  [NCH];
    logic [NCH-1:0] m_tick;
    logic           m_ack;
    logic           m_err;

    gerador_strobe #(
        .N_CH      (NCH),
        .WIDTH     (W),
        .DIV_RESET (DRST)
    ) dut (
        .clk_in     (clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_div     (wr_div),
        .wr_oneshot (wr_oneshot),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit ok;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c]   = DRST;
                m_edges[c] = 0;
                m_mode[c]  = 1'b0;
            end
            m_tick = '0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
        end else begin
            ok    = (int'(wr_ch) < NCH) && (wr_div != 0);
            m_ack = wr_en && ok;
            m_err = wr_en && !ok;
            for (int c = 0; c < NCH; c++) begin
                if (wr_en && ok && int'(wr_ch) == c) begin
                    m_div[c]   = int'(wr_div);
                    m_mode[c]  = ONESHOT_BUILD && wr_oneshot;
                    m_edges[c] = 0;
                    m_tick[c]  = 1'b0;
                end else if (restart) begin
                    m_edges[c] = 0;
                    m_tick[c]  = 1'b0;
                end else if (en) begin
                    m_edges[c]++;
                    if (m_mode[c])
                        m_tick[c] = (m_edges[c] == m_div[c]);
                    else
                        m_tick[c] = (m_edges[c] % m_div[c] == 0);
                end else begin
                    m_tick[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        restart    = 1'b0;
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_div     = '0;
        wr_oneshot = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        restart = 1'b1;
        wr_en = 1'b1;
        wr_ch = 2'd1;
        wr_div = 8'd3;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if ({tick, wr_ack, wr_err} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got tick=%b ack=%b err=%b, want all 0", k, tick, wr_ack, wr_err);
            end
        end
        idle_inputs();
        en = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_periodic();
        int cnt0, sum0;
        do_reset();
        en = 1'b1;
        cnt0 = 0;
        sum0 = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (tick[0] === 1'b1) begin
                cnt0++;
                sum0 += k;
            end
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL periodic cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        n_checks++;
        if (cnt0 != 5 || sum0 != 60) begin
            n_fail++;
            $display("FAIL periodic_positions: got %0d ticks (cycle sum %0d), want 5 ticks (sum 60 = 4+8+12+16+20)", cnt0, sum0);
        end
    endtask

    task automatic test_write();
        int ack_seen, t1_sum;
        do_reset();
        en = 1'b1;
        ack_seen = 0;
        t1_sum = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                wr_en = 1'b1;
                wr_ch = 2'd1;
                wr_div = 8'd3;
            end
            cycle();
            idle_inputs();
            if (wr_ack === 1'b1) ack_seen = k;
            if (tick[1] === 1'b1 && k <= 11) t1_sum += k;
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL write cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        n_checks++;
        if (ack_seen != 2 || t1_sum != 24) begin
            n_fail++;
            $display("FAIL write_timing: got ack after edge %0d, tick1 cycle sum %0d; want ack after edge 2, sum 24 (5+8+11)", ack_seen, t1_sum);
        end
    endtask

    task automatic test_invalid();
        int errs, acks;
        do_reset();
        en = 1'b1;
        errs = 0;
        acks = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd0;
            end else if (k == 4) begin
                wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd5;
            end
            cycle();
            idle_inputs();
            errs += int'(wr_err === 1'b1);
            acks += int'(wr_ack === 1'b1);
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL invalid cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        n_checks++;
        if (errs != 2 || acks != 0) begin
            n_fail++;
            $display("FAIL invalid_counts: got err=%0d ack=%0d, want err=2 ack=0", errs, acks);
        end
    endtask

    task automatic test_en_gap();
        int guard;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            en = !(k >= 3 && k <= 7);
            cycle();
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL en_gap cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        en = 1'b1;
        guard = 0;
        while ((m_edges[0] + 1) % m_div[0] != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        wr_en = 1'b1;
        wr_ch = 2'd0;
        wr_div = 8'd4;
        cycle();
        idle_inputs();
        n_checks++;
        if (tick[0] !== 1'b0 || wr_ack !== 1'b1 || guard >= 20) begin
            n_fail++;
            $display("FAIL write_on_terminal: got tick0=%b ack=%b (guard %0d), want tick0=0 ack=1", tick[0], wr_ack, guard);
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL post_terminal_write cyc %0d: got tick=%b, want tick=%b", k, tick, m_tick);
            end
        end
    endtask

    task automatic test_restart();
        int t_first;
        do_reset();
        en = 1'b1;
        t_first = 0;
        for (int k = 1; k <= 14; k++) begin
            restart = (k == 6);
            if (k == 6) begin
                wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd5;
            end
            cycle();
            idle_inputs();
            if (k > 6 && t_first == 0 && tick[0] === 1'b1) t_first = k;
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL restart cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        n_checks++;
        if (t_first != 10) begin
            n_fail++;
            $display("FAIL restart_phase: got first tick0 after restart at cycle %0d, want 10", t_first);
        end
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd7;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL rst_midcount cyc %0d: got tick=%b, want tick=%b", k, tick, m_tick);
            end
        end
    endtask

    task automatic test_back_to_back();
        int run;
        do_reset();
        en = 1'b1;
        run = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k >= 2 && k <= 5) begin
                wr_en = 1'b1;
                wr_ch = CHW'((k - 2) % NCH);
                wr_div = W'(k);
            end
            cycle();
            idle_inputs();
            if (wr_ack === 1'b1) run++;
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        n_checks++;
        if (run != 4) begin
            n_fail++;
            $display("FAIL back_to_back_acks: got %0d ack pulses, want 4", run);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 79) == 0);
            restart    = ($urandom_range(0, 29) == 0);
            en         = ($urandom_range(0, 7) != 0);
            wr_en      = ($urandom_range(0, 5) == 0);
            wr_ch      = CHW'($urandom_range(0, 3));
            wr_div     = W'($urandom_range(0, 9));
            wr_oneshot = 1'($urandom_range(0, 1));
            cycle();
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got tick=%b ack=%b err=%b, want tick=%b ack=%b err=%b",
                         k, tick, wr_ack, wr_err, m_tick, m_ack, m_err);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

`ifdef GERADOR_STROBE_ONESHOT_EN
    task automatic test_oneshot();
        int n0;
        do_reset();
        en = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd2; wr_oneshot = 1'b1;
        cycle();
        idle_inputs();
        n0 = 0;
        for (int k = 1; k <= 30; k++) begin
            restart = (k == 24);
            cycle();
            idle_inputs();
            if (tick[0] === 1'b1) n0++;
            n_checks++;
            if ({tick, wr_ack, wr_err} !== {m_tick, m_ack, m_err}) begin
                n_fail++;
                $display("FAIL oneshot cyc %0d: got tick=%b, want tick=%b", k, tick, m_tick);
            end
        end
        n_checks++;
        if (n0 != 2) begin
            n_fail++;
            $display("FAIL oneshot_count: got %0d tick0 pulses, want 2 (one per arming)", n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_write();
        test_invalid();
        test_en_gap();
        test_restart();
        test_back_to_back();
`ifdef GERADOR_STROBE_ONESHOT_EN
        test_oneshot();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
